ram_arbiter: RTL and testbench

//  Shares the single block RAM between the lookahead CPU (opc6/opc7 style) and one auxiliary requester (loader/debug/DMA).

---
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Arbitrates one synchronous block RAM between a lookahead CPU and an auxiliary requester.
// Aux takes idle CPU cycles, or steals a busy one after MAX_WAIT cycles by stalling the CPU for one cycle.
module ram_arbiter #(
    parameter int DSIZE    = 32,
    parameter int ASIZE    = 13,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             cpu_vpa,
    input  logic             cpu_vda,
    input  logic             cpu_rnw,
    input  logic [ASIZE-1:0] cpu_address,
    input  logic [DSIZE-1:0] cpu_dout,
    output logic [DSIZE-1:0] cpu_din,
    output logic             cpu_clken,
    input  logic             aux_req,
    input  logic             aux_rnw,
    input  logic [ASIZE-1:0] aux_address,
    input  logic [DSIZE-1:0] aux_wdata,
    output logic             aux_ack,
    output logic [DSIZE-1:0] aux_rdata,
    output logic             aux_rvalid,
    output logic             ram_cs_b,
    output logic             ram_rnw,
    output logic [ASIZE-1:0] ram_address,
    output logic [DSIZE-1:0] ram_din,
    input  logic [DSIZE-1:0] ram_dout
);
    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, FREE, STEAL, RECOVER} state_t;

    state_t           state_q, state_d, cur;
    logic [CW-1:0]    wait_q, wait_d;
    logic [DSIZE-1:0] hold_q, rdata_q;
    logic             rd_pend_q, rd_pend_d;
    logic             cpu_busy, grant;

    assign cpu_busy = cpu_vpa | cpu_vda;

    // cur classifies this cycle; holding reset forces CPU ownership so the outputs drop asynchronously.
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        cur     = IDLE;
        wait_d  = wait_q;
        state_d = IDLE;
        if (!reset_b) begin
            cur = IDLE;
        end else if (state_q == RECOVER) begin
            cur = RECOVER;
        end else if (!aux_req) begin
            wait_d = '0;
        end else if (!cpu_busy) begin
            cur    = FREE;
            wait_d = '0;
        end else if (wait_q == MAX_CNT) begin
            cur    = STEAL;
            wait_d = '0;
        end else begin
            wait_d = wait_q + 1'b1;
        end

        case (cur)
            STEAL:   state_d = RECOVER;
            FREE:    state_d = FREE;
            default: state_d = IDLE;
        endcase
    end

    assign grant     = (cur == FREE) || (cur == STEAL);
    assign rd_pend_d = grant & aux_rnw;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            hold_q    <= '0;
            rdata_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rd_pend_q <= rd_pend_d;
            if (cur == STEAL) begin
                hold_q <= ram_dout;
            end
            if (rd_pend_q) begin
                rdata_q <= ram_dout;
            end
        end
    end

    // The stolen cycle's RAM output belongs to the CPU's previous read; replay it while the CPU re-issues.
    assign cpu_din     = (state_q == RECOVER) ? hold_q : ram_dout;
    assign cpu_clken   = (cur != STEAL);
    assign aux_ack     = grant;
    assign aux_rvalid  = rd_pend_q;
    assign aux_rdata   = rd_pend_q ? ram_dout : rdata_q;

    assign ram_cs_b    = grant ? 1'b0 : !cpu_busy;
    assign ram_rnw     = grant ? aux_rnw : cpu_rnw;
    assign ram_address = grant ? aux_address : cpu_address;
    assign ram_din     = grant ? aux_wdata : cpu_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter: a transaction-level model predicts every cycle's
// grant, stall and data; a negedge monitor pops the predictions and compares against the DUT.
module tb_ram_arbiter;
    localparam int DSIZE    = 32;
    localparam int ASIZE    = 13;
    localparam int MAX_WAIT = 8;

    typedef struct packed {
        logic             vpa;
        logic             vda;
        logic             rnw;
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] dout;
    } cpu_t;

    typedef struct packed {
        logic             req;
        logic             rnw;
        logic [ASIZE-1:0] addr;
        logic [DSIZE-1:0] wdata;
    } aux_t;

    typedef struct {
        int               cyc;
        bit               ack;
        bit               clken;
        bit               cs_b;
        bit               rvalid;
        logic [DSIZE-1:0] rdata;
        bit               chk_cpu;
        logic [DSIZE-1:0] cpu_din;
    } exp_t;

    logic             clk, reset_b;
    logic             cpu_vpa, cpu_vda, cpu_rnw;
    logic [ASIZE-1:0] cpu_address;
    logic [DSIZE-1:0] cpu_dout, cpu_din;
    logic             cpu_clken;
    logic             aux_req, aux_rnw;
    logic [ASIZE-1:0] aux_address;
    logic [DSIZE-1:0] aux_wdata, aux_rdata;
    logic             aux_ack, aux_rvalid;
    logic             ram_cs_b, ram_rnw;
    logic [ASIZE-1:0] ram_address;
    logic [DSIZE-1:0] ram_din, ram_dout;

    ram_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_b(reset_b),
        .cpu_vpa(cpu_vpa), .cpu_vda(cpu_vda), .cpu_rnw(cpu_rnw),
        .cpu_address(cpu_address), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_clken(cpu_clken),
        .aux_req(aux_req), .aux_rnw(aux_rnw), .aux_address(aux_address), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .ram_cs_b(ram_cs_b), .ram_rnw(ram_rnw), .ram_address(ram_address),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DSIZE-1:0] init_val(input logic [ASIZE-1:0] a);
        if (a == 13'h010) return 32'hDEADBEEF;
        if (a == 13'h020) return 32'h12345678;
        return (DSIZE'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Synchronous RAM environment: registered read data, unwritten words read their preset pattern.
    logic [DSIZE-1:0] ram_mem [0:(1<<ASIZE)-1];
    bit               ram_wr  [0:(1<<ASIZE)-1];
    always @(posedge clk) begin
        if (!ram_cs_b) begin
            if (ram_rnw) begin
                ram_dout <= ram_wr[ram_address] ? ram_mem[ram_address] : init_val(ram_address);
            end else begin
                ram_mem[ram_address] <= ram_din;
                ram_wr[ram_address]  <= 1'b1;
            end
        end
    end

    // Reference model state
    logic [DSIZE-1:0] ref_mem [0:(1<<ASIZE)-1];
    int               m_wait;
    bit               m_recover, m_rd_pend, m_cpu_rd_pend, m_aux_wait;
    logic [DSIZE-1:0] m_rd_data, m_aux_held, m_cpu_rd_data;
    cpu_t             cur_cpu;
    aux_t             cur_aux;
    int               cyc;
    exp_t             sb[$];
    int               n_tests, n_fail;

    task automatic check(input string name, input logic [DSIZE-1:0] act, input logic [DSIZE-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cpu_t mk_cpu(input bit vpa, input bit vda, input bit rnw,
                                    input int addr, input logic [DSIZE-1:0] dout);
        cpu_t c;
        c.vpa = vpa; c.vda = vda; c.rnw = rnw; c.addr = ASIZE'(addr); c.dout = dout;
        return c;
    endfunction

    function automatic aux_t mk_aux(input bit req, input bit rnw, input int addr, input logic [DSIZE-1:0] wd);
        aux_t a;
        a.req = req; a.rnw = rnw; a.addr = ASIZE'(addr); a.wdata = wd;
        return a;
    endfunction

    function automatic cpu_t rnd_cpu();
        int k;
        k = $urandom_range(0, 9);
        return mk_cpu(k < 4, (k >= 3) && (k < 8), $urandom_range(0, 9) < 6,
                      $urandom_range(0, 15), $urandom);
    endfunction

    task automatic drive_pins();
        cpu_vpa     = cur_cpu.vpa;
        cpu_vda     = cur_cpu.vda;
        cpu_rnw     = cur_cpu.rnw;
        cpu_address = cur_cpu.addr;
        cpu_dout    = cur_cpu.dout;
        aux_req     = cur_aux.req;
        aux_rnw     = cur_aux.rnw;
        aux_address = cur_aux.addr;
        aux_wdata   = cur_aux.wdata;
    endtask

    // One clock cycle: a stalled CPU re-presents its op, a waiting aux keeps its request unless it abandons.
    task automatic tick(input cpu_t nc, input aux_t na, input bit drop);
        bit   busy, grant, steal;
        exp_t e;
        @(posedge clk);
        #1;
        if (!m_recover) cur_cpu = nc;
        if (!m_aux_wait) cur_aux = na;
        else if (drop)   cur_aux = '0;
        drive_pins();

        busy  = cur_cpu.vpa | cur_cpu.vda;
        grant = 1'b0;
        steal = 1'b0;
        if (!m_recover && cur_aux.req) begin
            if (!busy) grant = 1'b1;
            else if (m_wait >= MAX_WAIT) begin
                grant = 1'b1;
                steal = 1'b1;
            end
        end
        if (!m_recover) m_wait = (!cur_aux.req || grant) ? 0 : m_wait + 1;

        e.cyc     = cyc;
        e.ack     = grant;
        e.clken   = !steal;
        e.cs_b    = grant ? 1'b0 : !busy;
        e.rvalid  = m_rd_pend;
        e.rdata   = m_rd_pend ? m_rd_data : m_aux_held;
        e.chk_cpu = !steal && m_cpu_rd_pend;
        e.cpu_din = m_cpu_rd_data;
        sb.push_back(e);

        if (m_rd_pend) m_aux_held = m_rd_data;
        m_rd_pend = 1'b0;
        if (grant) begin
            if (cur_aux.rnw) begin
                m_rd_pend = 1'b1;
                m_rd_data = ref_mem[cur_aux.addr];
            end else begin
                ref_mem[cur_aux.addr] = cur_aux.wdata;
            end
        end
        if (!steal) begin
            if (busy && cur_cpu.rnw) begin
                m_cpu_rd_pend = 1'b1;
                m_cpu_rd_data = ref_mem[cur_cpu.addr];
            end else begin
                m_cpu_rd_pend = 1'b0;
                if (busy) ref_mem[cur_cpu.addr] = cur_cpu.dout;
            end
        end
        m_aux_wait = cur_aux.req && !grant;
        m_recover  = steal;
        cyc++;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("aux_ack@%0d", e.cyc), DSIZE'(aux_ack), DSIZE'(e.ack));
            check($sformatf("cpu_clken@%0d", e.cyc), DSIZE'(cpu_clken), DSIZE'(e.clken));
            check($sformatf("ram_cs_b@%0d", e.cyc), DSIZE'(ram_cs_b), DSIZE'(e.cs_b));
            check($sformatf("aux_rvalid@%0d", e.cyc), DSIZE'(aux_rvalid), DSIZE'(e.rvalid));
            check($sformatf("aux_rdata@%0d", e.cyc), aux_rdata, e.rdata);
            if (e.chk_cpu) check($sformatf("cpu_din@%0d", e.cyc), cpu_din, e.cpu_din);
        end
    end

    initial begin
        cpu_t idle_cpu;
        aux_t no_aux;
        idle_cpu = '0;
        no_aux   = '0;
        n_tests = 0; n_fail = 0; cyc = 0;
        m_wait = 0; m_recover = 0; m_rd_pend = 0; m_cpu_rd_pend = 0; m_aux_wait = 0;
        m_rd_data = '0; m_aux_held = '0; m_cpu_rd_data = '0;
        for (int i = 0; i < (1 << ASIZE); i++) ref_mem[i] = init_val(ASIZE'(i));

        // Reset with an idle CPU and a pending aux request: nothing may be granted.
        reset_b = 1'b0;
        cur_cpu = idle_cpu;
        cur_aux = mk_aux(1, 1, 'h010, '0);
        drive_pins();
        #12;
        check("rst_aux_ack", DSIZE'(aux_ack), 0);
        check("rst_cpu_clken", DSIZE'(cpu_clken), 1);
        check("rst_aux_rvalid", DSIZE'(aux_rvalid), 0);
        check("rst_aux_rdata", aux_rdata, 0);
        check("rst_ram_cs_b", DSIZE'(ram_cs_b), 1);
        cur_aux = no_aux;
        drive_pins();
        @(negedge clk);
        reset_b = 1'b1;

        // Aux read in an idle CPU cycle.
        tick(idle_cpu, mk_aux(1, 1, 'h010, '0), 0);
        tick(idle_cpu, no_aux, 0);
        tick(idle_cpu, no_aux, 0);

        // Busy CPU: aux write is stolen at the ninth cycle while the CPU read of 0x020 is in flight.
        for (int i = 0; i < 12; i++)
            tick(mk_cpu(0, 1, 1, (i == 7) ? 'h020 : 'h100 + i, '0),
                 (i == 0) ? mk_aux(1, 0, 'h030, 32'h55) : no_aux, 0);
        tick(mk_cpu(0, 1, 1, 'h030, '0), no_aux, 0);
        tick(mk_cpu(1, 0, 1, 'h020, '0), no_aux, 0);
        tick(idle_cpu, no_aux, 0);

        // Aux write with an idle CPU, then the CPU reads it back.
        tick(idle_cpu, mk_aux(1, 0, 'h040, 32'hCAFEF00D), 0);
        tick(mk_cpu(0, 1, 1, 'h040, '0), no_aux, 0);
        tick(idle_cpu, no_aux, 0);

        // Aux request held continuously against a busy CPU.
        for (int i = 0; i < 40; i++)
            tick(mk_cpu(1, 0, 1, $urandom_range(0, 15), '0), mk_aux(1, 1, $urandom_range(0, 15), '0), 0);
        tick(idle_cpu, no_aux, 0);

        // Reset asserted in the middle of a stolen cycle.
        for (int i = 0; i < MAX_WAIT; i++)
            tick(mk_cpu(0, 1, 1, 'h100 + i, '0), (i == 0) ? mk_aux(1, 1, 'h010, '0) : no_aux, 0);
        @(posedge clk);
        #1;
        check("steal_aux_ack", DSIZE'(aux_ack), 1);
        check("steal_cpu_clken", DSIZE'(cpu_clken), 0);
        #2;
        reset_b = 1'b0;
        #1;
        check("rst_steal_aux_ack", DSIZE'(aux_ack), 0);
        check("rst_steal_cpu_clken", DSIZE'(cpu_clken), 1);
        check("rst_steal_aux_rvalid", DSIZE'(aux_rvalid), 0);
        check("rst_steal_aux_rdata", aux_rdata, 0);
        check("rst_steal_ram_addr", DSIZE'(ram_address), DSIZE'(cur_cpu.addr));
        cur_cpu = idle_cpu;
        cur_aux = no_aux;
        drive_pins();
        @(negedge clk);
        reset_b = 1'b1;
        m_wait = 0; m_recover = 0; m_rd_pend = 0; m_cpu_rd_pend = 0; m_aux_wait = 0; m_aux_held = '0;

        // After reset the wait counter restarts from zero.
        for (int i = 0; i < 12; i++)
            tick(mk_cpu(0, 1, 1, 'h200 + i, '0), (i == 0) ? mk_aux(1, 0, 'h050, 32'hA5A5A5A5) : no_aux, 0);

        // Random traffic on a small address window so CPU and aux collide.
        for (int i = 0; i < 3000; i++)
            tick(rnd_cpu(),
                 ($urandom_range(0, 9) < 4) ? mk_aux(1, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom)
                                            : no_aux,
                 $urandom_range(0, 19) == 0);

        tick(idle_cpu, no_aux, 0);
        tick(idle_cpu, no_aux, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", DSIZE'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
